// File: rtl/learn_costs_param_if.sv
// Memory bus between the neighbor-table updater and a single-port,
// synchronous-read memory.
//   address     : word address, owned by the master
//   wr_en       : write strobe, owned by the master
//   mem_wr_data : write data, owned by the master
//   mem_rd_data : read data, valid one edge after the address was sampled
interface learn_costs_param_if #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] mem_wr_data;
    logic [WORD_WIDTH-1:0] mem_rd_data;

    modport master (
        output address,
        output wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  address,
        input  wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/learn_costs_param.sv
// Neighbor cost table updater. Looks up fsourceID in a table held in
// external memory and either refreshes the matching entry (overwrite or
// learned average) or appends a new entry and bumps the entry count.
//   clock, nrst        : rising-edge clock, asynchronous active-low reset
//   en, mode           : start request (IDLE only), 0 overwrite / 1 average
//   fsourceID..initial_epsilon : neighbor update fields, latched on start
//   mem                : memory bus (master side)
//   busy, done         : operation in progress, one-cycle completion pulse
//   hit, full_err      : result flags, valid with done, held until next start
//   entry_idx          : hit or inserted entry index, 0 on full_err
module learn_costs_param #(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter int unsigned MAX_NEIGHBORS = 32,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned ALPHA_SHIFT   = 2
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [WORD_WIDTH-1:0] fsourceID,
    input  logic [WORD_WIDTH-1:0] fbatteryStat,
    input  logic [WORD_WIDTH-1:0] fValue,
    input  logic [WORD_WIDTH-1:0] fclusterID,
    input  logic [WORD_WIDTH-1:0] initial_epsilon,
    learn_costs_param_if.master   mem,
    output logic                  busy,
    output logic                  done,
    output logic                  hit,
    output logic                  full_err,
    output logic [ADDR_WIDTH-1:0] entry_idx
);

    localparam int unsigned IDX_W  = $clog2(MAX_NEIGHBORS + 1);
    localparam int unsigned STEP_W = 2;
    localparam int unsigned K_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        RD_ID,
        CMP,
        RD_VAL,
        WR_ENTRY,
        WR_CNT,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [K_W-1:0]        k_q, k_d;
    logic                  mode_q, mode_d;
    logic [WORD_WIDTH-1:0] id_q, id_d;
    logic [WORD_WIDTH-1:0] bat_q, bat_d;
    logic [WORD_WIDTH-1:0] val_q, val_d;
    logic [WORD_WIDTH-1:0] clu_q, clu_d;
    logic [WORD_WIDTH-1:0] eps_q, eps_d;
    logic [WORD_WIDTH-1:0] old_eps_q, old_eps_d;
    logic [WORD_WIDTH-1:0] old_val_q, old_val_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  hit_q, hit_d;
    logic                  full_q, full_d;
    logic [ADDR_WIDTH-1:0] eidx_q, eidx_d;

    logic signed [WORD_WIDTH:0] diff_c;
    logic signed [WORD_WIDTH:0] delta_c;
    logic [WORD_WIDTH-1:0]      avg_c;
    logic [WORD_WIDTH-1:0]      eps_dec_c;
    logic [WORD_WIDTH-1:0]      words_c [5];
    logic [IDX_W-1:0]           cnt_rd_c;
    logic                       miss_go;
    logic [IDX_W-1:0]           miss_cnt;

    // Address of word k of entry i.
    function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [IDX_W-1:0] i,
                                                         input logic [K_W-1:0]   k);
        return ADDR_WIDTH'(BASE_ADDR + 32'd1 + 32'd5 * 32'(i) + 32'(k));
    endfunction

    // Learned average: difference carried in one extra bit so it cannot wrap.
    always_comb begin
        diff_c    = $signed({val_q[WORD_WIDTH-1], val_q})
                  - $signed({old_val_q[WORD_WIDTH-1], old_val_q});
        delta_c   = diff_c >>> ALPHA_SHIFT;
        avg_c     = old_val_q + delta_c[WORD_WIDTH-1:0];
        eps_dec_c = (old_eps_q == '0) ? '0 : old_eps_q - WORD_WIDTH'(1);
    end

    // Word images for the entry being written; hit_q selects update vs insert.
    always_comb begin
        words_c[0] = id_q;
        words_c[1] = bat_q;
        words_c[2] = (hit_q && mode_q) ? avg_c : val_q;
        words_c[3] = clu_q;
        words_c[4] = hit_q ? eps_dec_c : eps_q;
    end

    // Stored count, clamped to table capacity.
    always_comb begin
        if (mem.mem_rd_data > WORD_WIDTH'(MAX_NEIGHBORS)) begin
            cnt_rd_c = IDX_W'(MAX_NEIGHBORS);
        end else begin
            cnt_rd_c = IDX_W'(mem.mem_rd_data);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        mode_d    = mode_q;
        id_d      = id_q;
        bat_d     = bat_q;
        val_d     = val_q;
        clu_d     = clu_q;
        eps_d     = eps_q;
        old_eps_d = old_eps_q;
        old_val_d = old_val_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hit_d     = hit_q;
        full_d    = full_q;
        eidx_d    = eidx_q;
        miss_go   = 1'b0;
        miss_cnt  = cnt_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    mode_d  = mode;
                    id_d    = fsourceID;
                    bat_d   = fbatteryStat;
                    val_d   = fValue;
                    clu_d   = fclusterID;
                    eps_d   = initial_epsilon;
                    busy_d  = 1'b1;
                    hit_d   = 1'b0;
                    full_d  = 1'b0;
                    eidx_d  = '0;
                    addr_d  = ADDR_WIDTH'(BASE_ADDR);
                    step_d  = '0;
                    state_d = RD_CNT;
                end
            end

            // Step 0 waits out the read latency, step 1 consumes the count.
            RD_CNT: begin
                if (step_q == '0) begin
                    step_d = STEP_W'(1);
                end else begin
                    cnt_d = cnt_rd_c;
                    idx_d = '0;
                    if (cnt_rd_c == '0) begin
                        miss_go  = 1'b1;
                        miss_cnt = cnt_rd_c;
                    end else begin
                        addr_d  = entry_addr(IDX_W'(0), K_W'(0));
                        state_d = RD_ID;
                    end
                end
            end

            RD_ID: begin
                state_d = CMP;
            end

            CMP: begin
                if (mem.mem_rd_data == id_q) begin
                    hit_d   = 1'b1;
                    eidx_d  = ADDR_WIDTH'(idx_q);
                    addr_d  = entry_addr(idx_q, K_W'(4));
                    step_d  = '0;
                    state_d = RD_VAL;
                end else if (idx_q + IDX_W'(1) == cnt_q) begin
                    miss_go  = 1'b1;
                    miss_cnt = cnt_q;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    addr_d  = entry_addr(idx_q + IDX_W'(1), K_W'(0));
                    state_d = RD_ID;
                end
            end

            // Pipelined reads: epsilon address first, value address next.
            RD_VAL: begin
                case (step_q)
                    2'd0: begin
                        addr_d = entry_addr(idx_q, K_W'(2));
                        step_d = STEP_W'(1);
                    end
                    2'd1: begin
                        old_eps_d = mem.mem_rd_data;
                        step_d    = STEP_W'(2);
                    end
                    default: begin
                        old_val_d = mem.mem_rd_data;
                        wr_en_d   = 1'b1;
                        k_d       = K_W'(1);
                        addr_d    = entry_addr(idx_q, K_W'(1));
                        wdata_d   = bat_q;
                        state_d   = WR_ENTRY;
                    end
                endcase
            end

            // One word per cycle; the count is only touched after word 4.
            WR_ENTRY: begin
                if (k_q == K_W'(4)) begin
                    if (hit_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FINISH;
                    end else begin
                        wr_en_d = 1'b1;
                        addr_d  = ADDR_WIDTH'(BASE_ADDR);
                        wdata_d = WORD_WIDTH'(cnt_q) + WORD_WIDTH'(1);
                        state_d = WR_CNT;
                    end
                end else begin
                    wr_en_d = 1'b1;
                    k_d     = k_q + K_W'(1);
                    addr_d  = entry_addr(idx_q, k_q + K_W'(1));
                    wdata_d = words_c[k_q + K_W'(1)];
                end
            end

            WR_CNT: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = FINISH;
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared miss handling: table full or start an insert at index count.
        if (miss_go) begin
            if (miss_cnt == IDX_W'(MAX_NEIGHBORS)) begin
                full_d  = 1'b1;
                eidx_d  = '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = FINISH;
            end else begin
                idx_d   = miss_cnt;
                eidx_d  = ADDR_WIDTH'(miss_cnt);
                k_d     = '0;
                wr_en_d = 1'b1;
                addr_d  = entry_addr(miss_cnt, K_W'(0));
                wdata_d = id_q;
                state_d = WR_ENTRY;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            mode_q    <= 1'b0;
            id_q      <= '0;
            bat_q     <= '0;
            val_q     <= '0;
            clu_q     <= '0;
            eps_q     <= '0;
            old_eps_q <= '0;
            old_val_q <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            full_q    <= 1'b0;
            eidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            mode_q    <= mode_d;
            id_q      <= id_d;
            bat_q     <= bat_d;
            val_q     <= val_d;
            clu_q     <= clu_d;
            eps_q     <= eps_d;
            old_eps_q <= old_eps_d;
            old_val_q <= old_val_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            full_q    <= full_d;
            eidx_q    <= eidx_d;
        end
    end

    assign mem.address     = addr_q;
    assign mem.wr_en       = wr_en_q;
    assign mem.mem_wr_data = wdata_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign hit             = hit_q;
    assign full_err        = full_q;
    assign entry_idx       = eidx_q;

endmodule

// File: tb/tb_learn_costs_param.sv
// Scoreboard bench for learn_costs_param: a table-level reference model
// predicts each operation's flags, index, written words and latency bound.
module tb_learn_costs_param;

    localparam int WW    = 16;
    localparam int AW    = 11;
    localparam int MAXN  = 32;
    localparam int BASE  = 0;
    localparam int ALPHA = 2;

    logic          clock = 1'b0;
    logic          nrst;
    logic          en, mode;
    logic [WW-1:0] fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon;
    logic          busy, done, hit, full_err;
    logic [AW-1:0] entry_idx;

    learn_costs_param_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    learn_costs_param #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAX_NEIGHBORS(MAXN),
        .BASE_ADDR(BASE), .ALPHA_SHIFT(ALPHA)
    ) dut (
        .clock(clock), .nrst(nrst), .en(en), .mode(mode),
        .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
        .fclusterID(fclusterID), .initial_epsilon(initial_epsilon),
        .mem(bus.master),
        .busy(busy), .done(done), .hit(hit), .full_err(full_err),
        .entry_idx(entry_idx)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic            hit;
        logic            full;
        logic            has_entry;
        logic [AW-1:0]   eidx;
        logic [AW-1:0]   base;
        logic [31:0]     writes;
        logic [31:0]     budget;
        logic [31:0]     acc;
        logic [4:0][15:0] words;
        logic [15:0]     cnt_word;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [WW-1:0] dmem    [0:(1<<AW)-1];
    logic [WW-1:0] ref_mem [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [WW-1:0] bd_data;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            wr_seen = 0;
    logic          prev_done = 1'b0;

    // Memory model: synchronous read, write when wr_en; backdoor for preload.
    always @(posedge clock) begin
        if (bd_we) dmem[bd_addr] <= bd_data;
        else if (bus.wr_en) dmem[bus.address] <= bus.mem_wr_data;
        bus.mem_rd_data <= dmem[bus.address];
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int ea(input int i, input int k);
        return BASE + 1 + 5 * i + k;
    endfunction

    task automatic bd_write(input int a, input logic [WW-1:0] d);
        ref_mem[a] = d;
        bd_addr = AW'(a);
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clock);
        bd_we   = 1'b0;
    endtask

    task automatic set_entry(input int i, input logic [WW-1:0] id, bat, val, clu, eps);
        bd_write(ea(i, 0), id);
        bd_write(ea(i, 1), bat);
        bd_write(ea(i, 2), val);
        bd_write(ea(i, 3), clu);
        bd_write(ea(i, 4), eps);
    endtask

    // Reference: table semantics on ref_mem, independent of the FSM.
    task automatic ref_op(input logic m, input logic [WW-1:0] id, bat, val, clu, eps,
                          output exp_t e);
        int cnt, found, ov, d, nv;
        logic [WW-1:0] oe;
        e = '0;
        cnt = int'(ref_mem[BASE]);
        if (cnt > MAXN) cnt = MAXN;
        found = -1;
        for (int i = 0; i < cnt; i++) begin
            if (ref_mem[ea(i, 0)] == id) begin
                found = i;
                break;
            end
        end
        e.budget = 32'(2 * (cnt + 1) + 10);
        if (found >= 0) begin
            ov = int'($signed(ref_mem[ea(found, 2)]));
            d  = int'($signed(val)) - ov;
            nv = m ? ov + (d >>> ALPHA) : int'($signed(val));
            oe = ref_mem[ea(found, 4)];
            ref_mem[ea(found, 1)] = bat;
            ref_mem[ea(found, 2)] = 16'(nv);
            ref_mem[ea(found, 3)] = clu;
            ref_mem[ea(found, 4)] = (oe == 16'd0) ? 16'd0 : oe - 16'd1;
            e.hit = 1'b1; e.has_entry = 1'b1; e.writes = 4;
            e.eidx = AW'(found); e.base = AW'(ea(found, 0));
        end else if (cnt == MAXN) begin
            e.full = 1'b1; e.writes = 0;
        end else begin
            ref_mem[ea(cnt, 0)] = id;
            ref_mem[ea(cnt, 1)] = bat;
            ref_mem[ea(cnt, 2)] = val;
            ref_mem[ea(cnt, 3)] = clu;
            ref_mem[ea(cnt, 4)] = eps;
            ref_mem[BASE] = 16'(cnt + 1);
            e.has_entry = 1'b1; e.writes = 6;
            e.eidx = AW'(cnt); e.base = AW'(ea(cnt, 0));
        end
        if (e.has_entry) for (int k = 0; k < 5; k++) e.words[k] = ref_mem[int'(e.base) + k];
        e.cnt_word = ref_mem[BASE];
    endtask

    // Issue one operation; hold keeps en high until done is seen.
    task automatic do_op(input logic m, input logic [WW-1:0] id, bat, val, clu, eps,
                         input logic hold);
        exp_t e;
        bit   got;
        ref_op(m, id, bat, val, clu, eps, e);
        e.acc = 32'(cyc + 1);
        mode = m; fsourceID = id; fbatteryStat = bat; fValue = val;
        fclusterID = clu; initial_epsilon = eps;
        en = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        if (!hold) en = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        en = 1'b0;
        if (!got) check("op_timeout", 0, 1);
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_hit"}, 32'(hit), 0);
        check({tag, "_full_err"}, 32'(full_err), 0);
        check({tag, "_entry_idx"}, 32'(entry_idx), 0);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        check({tag, "_address"}, 32'(bus.address), 0);
        check({tag, "_wr_data"}, 32'(bus.mem_wr_data), 0);
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clock) begin
        if (!nrst) begin
            wr_seen   = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_single_cycle", 32'(done), 0);
            if (bus.wr_en) wr_seen++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("hit", 32'(hit), 32'(mon_e.hit));
                    check("full_err", 32'(full_err), 32'(mon_e.full));
                    check("entry_idx", 32'(entry_idx), 32'(mon_e.eidx));
                    check("busy_low_at_done", 32'(busy), 0);
                    check("write_count", 32'(wr_seen), mon_e.writes);
                    check("count_word", 32'(dmem[BASE]), 32'(mon_e.cnt_word));
                    check("latency_in_budget",
                          32'((cyc - int'(mon_e.acc)) <= int'(mon_e.budget)), 1);
                    if (mon_e.has_entry)
                        for (int k = 0; k < 5; k++)
                            check($sformatf("entry_word%0d", k),
                                  32'(dmem[int'(mon_e.base) + k]), 32'(mon_e.words[k]));
                end
                wr_seen = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [WW-1:0] saved_cnt;
        bit            got;
        nrst = 1'b0; en = 1'b0; mode = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        fsourceID = '0; fbatteryStat = '0; fValue = '0; fclusterID = '0; initial_epsilon = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        bd_write(BASE, 16'd0);
        nrst = 1'b1;

        // Empty table insert, first en right after reset release.
        do_op(1'b0, 16'd1, 16'd5, 16'd10, 16'd11, 16'd1, 1'b0);

        // Hit in mode 0 on entry 2.
        bd_write(BASE, 16'd3);
        set_entry(0, 16'd100, 16'd1, 16'd2, 16'd3, 16'd4);
        set_entry(1, 16'd101, 16'd1, 16'd2, 16'd3, 16'd4);
        set_entry(2, 16'd31, 16'd7, 16'd20, 16'd8, 16'd3);
        do_op(1'b0, 16'd31, 16'd9, 16'd10, 16'd12, 16'd5, 1'b0);

        // Hit in mode 1: learned average, positive and negative steps.
        set_entry(2, 16'd31, 16'd7, 16'd20, 16'd8, 16'd3);
        do_op(1'b1, 16'd31, 16'd9, 16'd10, 16'd12, 16'd5, 1'b0);
        set_entry(2, 16'd31, 16'd7, 16'hFFF8, 16'd8, 16'd0);
        do_op(1'b1, 16'd31, 16'd9, 16'd8, 16'd12, 16'd5, 1'b0);

        // Full table, en held high through the operation.
        bd_write(BASE, 16'(MAXN));
        for (int i = 0; i < MAXN; i++) set_entry(i, 16'(200 + i), 16'd1, 16'd2, 16'd3, 16'd4);
        do_op(1'b0, 16'd999, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        repeat (3) @(negedge clock);
        check("held_en_single_op", 32'(busy), 0);
        check("held_en_no_pending", 32'(exp_q.size()), 0);

        // Stored count above capacity clamps to full.
        bd_write(BASE, 16'd40);
        do_op(1'b1, 16'd998, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        // Hit on the last entry of a full table.
        bd_write(BASE, 16'(MAXN));
        do_op(1'b0, 16'(200 + MAXN - 1), 16'd6, 16'd7, 16'd8, 16'd9, 1'b0);

        // Reset during WR_ENTRY of an insert.
        bd_write(BASE, 16'd2);
        set_entry(0, 16'd50, 16'd1, 16'd2, 16'd3, 16'd4);
        set_entry(1, 16'd51, 16'd1, 16'd2, 16'd3, 16'd4);
        saved_cnt = ref_mem[BASE];
        mode = 1'b0; fsourceID = 16'd52; fbatteryStat = 16'd1; fValue = 16'd2;
        fclusterID = 16'd3; initial_epsilon = 16'd4;
        en = 1'b1;
        @(negedge clock);
        en = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (bus.wr_en) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("abort_reached_write", 32'(got), 1);
        repeat (2) @(negedge clock);
        nrst = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clock);
        check("abort_count_unchanged", 32'(dmem[BASE]), 32'(saved_cnt));
        nrst = 1'b1;
        do_op(1'b0, 16'd53, 16'd21, 16'd22, 16'd23, 16'd24, 1'b0);

        // Randomized operations on a fresh table.
        bd_write(BASE, 16'd0);
        for (int n = 0; n < 60; n++) begin
            do_op(1'($urandom_range(0, 1)), 16'($urandom_range(0, 40)), 16'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/learn_costs_param.md
LEARN_COSTS_PARAM -- requirements
Module: learn_costs_param

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, data/memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, memory address width.
REQ-003 SHALL have parameter MAX_NEIGHBORS, default 32, table capacity in entries.
REQ-004 SHALL have parameter BASE_ADDR, default 0, address of the table count word.
REQ-005 SHALL have parameter ALPHA_SHIFT, default 2, learning-rate shift for mode 1.
REQ-006 SHALL have ports: clock  in  1  sole clock, rising edge; nrst  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: en  in  1  start request; mode  in  1  0 = overwrite value, 1 = learned average.
REQ-008 SHALL have ports: fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon  in  WORD_WIDTH each  neighbor update fields.
REQ-009 SHALL have ports: address  out  ADDR_WIDTH; wr_en  out  1; mem_rd_data  in  WORD_WIDTH; mem_wr_data  out  WORD_WIDTH.
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; hit  out  1; full_err  out  1; entry_idx  out  ADDR_WIDTH.

Function
REQ-011 Memory SHALL be single-port, synchronous read: address at edge t gives mem_rd_data valid after edge t+1; write when wr_en high at an edge.
REQ-012 Table layout SHALL be: BASE_ADDR = entry count; entry i word k at BASE_ADDR+1+5*i+k, k: 0 id, 1 battery, 2 value, 3 cluster, 4 epsilon.
REQ-013 FSM SHALL have states IDLE, RD_CNT, RD_ID, CMP, RD_VAL, WR_ENTRY, WR_CNT, FINISH.
REQ-014 In IDLE, en high at an edge SHALL latch all input fields and mode, set busy, and go to RD_CNT; en in any other state SHALL be ignored.
REQ-015 RD_CNT SHALL read the count; counts above MAX_NEIGHBORS SHALL be clamped to MAX_NEIGHBORS.
REQ-016 RD_ID/CMP SHALL scan entries 0..count-1 in order, comparing word 0 to latched fsourceID; the first match is the hit.
REQ-017 On hit, mode 0: SHALL write battery, value = fValue, cluster, epsilon = max(old epsilon - 1, 0); count unchanged; no WR_CNT.
REQ-018 On hit, mode 1: SHALL read old value (RD_VAL) and write value = old + ((fValue - old) >>> ALPHA_SHIFT), signed, difference in WORD_WIDTH+1 bits, result truncated to WORD_WIDTH; other fields as REQ-017.
REQ-019 On miss with count < MAX_NEIGHBORS: SHALL write all 5 words of entry at index count (epsilon = initial_epsilon, value = fValue for either mode), then write count+1 in WR_CNT.
REQ-020 Entry words SHALL be written before the count word, so an aborted insert never becomes visible.
REQ-021 On miss with count = MAX_NEIGHBORS: SHALL perform no write, set full_err, hit = 0.
REQ-022 Empty table (count 0) SHALL be treated as a miss with zero scan cycles.
REQ-023 FINISH SHALL pulse done for exactly one cycle, drop busy in the same cycle, and return to IDLE; hit, full_err, entry_idx SHALL be valid with done and held until the next accepted en.
REQ-024 entry_idx SHALL be the hit index or the inserted index; 0 on full_err.
REQ-025 done SHALL occur no later than 2*(count+1)+10 cycles after the accepting edge.
REQ-026 wr_en SHALL be high only in WR_ENTRY and WR_CNT, one word per cycle.

Reset
REQ-027 nrst low SHALL immediately force IDLE, busy 0, done 0, hit 0, full_err 0, entry_idx 0, wr_en 0, address 0, mem_wr_data 0.
REQ-028 Reset during an operation SHALL abort it with no further writes; memory contents are not cleared.
REQ-029 First en SHALL be accepted at the first rising edge after nrst deasserts.

Verification
REQ-030 Count 0, en with fsourceID=1, fValue=10, initial_epsilon=1 -> entry 0 = {1,5,10,11,1}, count 1, done, hit 0, entry_idx 0.
REQ-031 Preload count 3, entry 2 id 31 value 20 epsilon 3; mode 0, fsourceID=31, fValue=10 -> value 10, epsilon 2, count 3, hit 1, entry_idx 2.
REQ-032 Same preload, mode 1, ALPHA_SHIFT 2 -> value 20+((10-20)>>>2)=17, hit 1; repeat with old value -8, fValue 8 -> -4.
REQ-033 Count = MAX_NEIGHBORS, new id -> no wr_en pulses, full_err 1, done 1 cycle; en held high through operation -> exactly one operation.
REQ-034 nrst asserted during WR_ENTRY of an insert -> outputs reset immediately, count word unchanged, next operation correct.
